// File: rtl/f_seq_detector_pkg.sv
// Shared definitions for the 1011 sequence detector: FSM state encodings,
// default counter width and the pattern being searched for.
package f_seq_detector_pkg;

  localparam logic [2:0] S0    = 3'd0;
  localparam logic [2:0] S1    = 3'd1;
  localparam logic [2:0] S10   = 3'd2;
  localparam logic [2:0] S101  = 3'd3;
  localparam logic [2:0] S1011 = 3'd4;

  localparam int CNT_W_DEF = 8;

  // Documentation only: the serial pattern the FSM recognises, oldest bit first.
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/f_seq_detector_sat_counter.sv
// Saturating up-counter with sticky saturation flag. clr wins over inc.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count increments up to all-ones; sat is raised on the step that lands there.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_MAX - 1'b1) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/f_seq_detector.sv
// Moore FSM detecting the serial pattern 1011 on f_in, with a saturating
// match counter and a valid/ready event output with sticky overflow flag.
// Build option: define F_SEQ_OVERLAP_EN for overlapping detection (the
// trailing "1" of a match may start the next one through S10); the default
// build is non-overlapping.
module f_seq_detector
  import f_seq_detector_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             f_in,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_ovf
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       hit;

  // Next-state decode; with en low the state simply holds.
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        S0:      state_nxt = f_in ? S1    : S0;
        S1:      state_nxt = f_in ? S1    : S10;
        S10:     state_nxt = f_in ? S101  : S0;
        S101:    state_nxt = f_in ? S1011 : S10;
`ifdef F_SEQ_OVERLAP_EN
        S1011:   state_nxt = f_in ? S1    : S10;
`else
        S1011:   state_nxt = f_in ? S1    : S0;
`endif
        default: state_nxt = S0;
      endcase
    end
  end

  // S1011 always exits on the next enabled bit, so hit is one strobe per match.
  assign hit = en && (state_nxt == S1011);

  // State register and registered Moore output (match mirrors state == S1011).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
      match <= 1'b0;
    end else begin
      state <= state_nxt;
      match <= (state_nxt == S1011);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (hit),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

  // Event handshake: a new hit keeps/raises valid; an accepted event without a
  // fresh hit drops it. A hit on top of an unaccepted event merges and flags ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_ovf   <= 1'b0;
    end else begin
      if (hit)
        evt_valid <= 1'b1;
      else if (evt_valid && evt_ready)
        evt_valid <= 1'b0;

      if (clr)
        evt_ovf <= 1'b0;
      else if (hit && evt_valid && !evt_ready)
        evt_ovf <= 1'b1;
    end
  end

endmodule
